apb_master: RTL



---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_wait_timer.sv | 36 +++
 rtl/apb_master.sv | 136 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared defaults and master state encoding for the APB requester and its bench.
package apb_pkg;

  localparam int WIDTH      = 8;
  localparam int MEM_DEPTH  = 16;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int TIMEOUT    = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mstate_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter; expired_o is combinational.
// It flags the stall cycle whose increment would reach TIMEOUT.
module apb_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one command -> SETUP, ACCESS (waits up to TIMEOUT), RESP.
// Zero-wait slave: response 3 cycles after accept; RESP holds until rsp_ready_i.
module apb_master
  import apb_pkg::*;
#(
  parameter int WIDTH      = apb_pkg::WIDTH,
  parameter int MEM_DEPTH  = apb_pkg::MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int TIMEOUT    = apb_pkg::TIMEOUT
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [WIDTH-1:0]      cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [WIDTH-1:0]      pwdata_o,
  input  logic [WIDTH-1:0]      prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  apb_mstate_e state_q, state_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [WIDTH-1:0]      pwdata_q, pwdata_d;

  logic accept;
  logic stall;
  logic expired;

  // cmd_ready_q is low for the first IDLE cycle after reset, so gate on it.
  assign accept = (state_q == IDLE) && cmd_ready_q && cmd_valid_i;
  assign stall  = (state_q == ACCESS) && !pready_i;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk_i    (pclk_i),
    .rst_i    (preset_i),
    .clear_i  (accept),
    .en_i     (stall),
    .expired_o(expired)
  );

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || expired) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      pwrite_d = cmd_write_i;
      paddr_d  = cmd_addr_i;
      pwdata_d = cmd_write_i ? cmd_wdata_i : '0;
    end
    if (state_q == ACCESS) begin
      if (pready_i) begin
        rsp_rdata_d = pwrite_q ? '0 : prdata_i;
        rsp_err_d   = pslverr_i;
      end else if (expired) begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
      end
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;

endmodule
